// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared control struct and constants for the MIPS pipeline
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t      CTRL_BUBBLE = '0;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  localparam logic [2:0] FWD_REG   = 3'b001;
  localparam logic [2:0] FWD_EXMEM = 3'b010;
  localparam logic [2:0] FWD_MEMWB = 3'b100;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// load_use_detect : combinational load-use hazard compare (EX load vs ID read)
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard
);

  // $0 is hardwired, so a load into it can never feed a consumer
  assign hazard = ex_valid & ex_mem_read & (ex_rt != REG_ZERO) & id_valid &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe.sv
// ============================================================================
// id_ex_pipe : ID/EX register with load-use stall, flush bubbles, mem freeze
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  ctrl_t             id_ctrl,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output ctrl_t             ex_ctrl,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_valid;
  logic [4:0]        r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_rdata1, r_rdata2, r_imm;
  ctrl_t             r_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_hazard;
  logic w_bubble;
  logic w_front_go;

  load_use_detect u_load_use_detect (
    .ex_valid    (r_valid),
    .ex_mem_read (r_ctrl.mem_read),
    .ex_rt       (r_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (w_hazard)
  );

  assign w_bubble = flush | w_hazard;

  // A flush overrides a hazard stall; mem_busy is ignored while in reset
  assign w_front_go  = ~rst_n | (~mem_busy & (flush | ~w_hazard));
  assign pc_write    = w_front_go;
  assign if_id_write = w_front_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_ctrl   <= CTRL_BUBBLE;
    end else if (!mem_busy) begin
      if (w_bubble) begin
        r_valid  <= 1'b0;
        r_rs     <= '0;
        r_rt     <= '0;
        r_rd     <= '0;
        r_rdata1 <= '0;
        r_rdata2 <= '0;
        r_imm    <= '0;
        r_ctrl   <= CTRL_BUBBLE;
      end else begin
        r_valid  <= id_valid;
        r_rs     <= id_rs;
        r_rt     <= id_rt;
        r_rd     <= id_rd;
        r_rdata1 <= id_rdata1;
        r_rdata2 <= id_rdata2;
        r_imm    <= id_imm;
        r_ctrl   <= id_valid ? id_ctrl : CTRL_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (flush) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (w_hazard) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign ex_valid  = r_valid;
  assign ex_rs     = r_rs;
  assign ex_rt     = r_rt;
  assign ex_rd     = r_rd;
  assign ex_rdata1 = r_rdata1;
  assign ex_rdata2 = r_rdata2;
  assign ex_imm    = r_imm;
  assign ex_ctrl   = r_ctrl;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// ============================================================================
// tb_id_ex_pipe : directed self-checking bench for id_ex_pipe
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipe;
  import pipe_pkg::*;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int SMALL_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm;
  ctrl_t             id_ctrl;
  logic              flush, mem_busy;

  logic              ex_valid;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm;
  ctrl_t             ex_ctrl;
  logic              pc_write, if_id_write;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  // narrow-counter copy so saturation is reachable in a short run
  logic              s_valid;
  logic [4:0]        s_rs, s_rt, s_rd;
  logic [DATA_W-1:0] s_rdata1, s_rdata2, s_imm;
  ctrl_t             s_ctrl;
  logic              s_pc_write, s_if_id_write;
  logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .mem_busy(mem_busy),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe #(.DATA_W(DATA_W), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .mem_busy(mem_busy),
    .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm),
    .ex_ctrl(s_ctrl), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // lw: reg_write, mem_read, mem_to_reg, alu_src, alu_op=000
  localparam ctrl_t C_LW  = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0,
                              mem_to_reg:1'b1, alu_src:1'b1, reg_dst:1'b0, alu_op:3'b000};
  // add: reg_write, reg_dst, alu_op=010
  localparam ctrl_t C_ADD = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0,
                              mem_to_reg:1'b0, alu_src:1'b0, reg_dst:1'b1, alu_op:3'b010};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input ctrl_t c);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = c;
  endtask

  task automatic set_idle;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_BUBBLE);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; mem_busy = 1'b1;
    set_idle();
    #2;
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1)
      $display("FAIL reset_pc_write: got %b/%b expected 1/1", pc_write, if_id_write); else n_pass++;
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_BUBBLE || ex_rs !== 5'd0 || ex_rdata1 !== 32'h0)
      $display("FAIL reset_ex: got valid=%b ctrl=%h rs=%0d d1=%h expected 0", ex_valid, ex_ctrl, ex_rs, ex_rdata1); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); else n_pass++;
    @(negedge clk);
    mem_busy = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || pc_write !== 1'b1 || stall_cnt !== 16'd0)
      $display("FAIL reset_release: got valid=%b pc=%b stall=%0d expected 0/1/0", ex_valid, pc_write, stall_cnt); else n_pass++;
  endtask

  task automatic test_lw_zero;
    set_id(1'b1, 5'd2, 5'd0, 5'd0, 32'h10, 32'h0, 32'h4, C_LW);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 5'd6, 32'h0, 32'h77, 32'h0, C_ADD);
    #1;
    n_checks++; if (pc_write !== 1'b1)
      $display("FAIL lw_zero_pc_write: got %b expected 1", pc_write); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd0 || ex_rt !== 5'd7 || ex_ctrl !== C_ADD || stall_cnt !== 16'd0)
      $display("FAIL lw_zero_ex: got valid=%b rs=%0d rt=%0d ctrl=%h stall=%0d expected 1/0/7/%h/0",
               ex_valid, ex_rs, ex_rt, ex_ctrl, stall_cnt, C_ADD); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_load_use;
    set_id(1'b1, 5'd2, 5'd5, 5'd0, 32'h100, 32'h0, 32'h8, C_LW);
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rt !== 5'd5 || ex_ctrl !== C_LW || ex_imm !== 32'h8)
      $display("FAIL lw_enter: got valid=%b rt=%0d ctrl=%h imm=%h expected 1/5/%h/8", ex_valid, ex_rt, ex_ctrl, ex_imm, C_LW); else n_pass++;
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 32'hAAAA_0005, 32'hBBBB_0007, 32'h0, C_ADD);
    #1;
    n_checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0)
      $display("FAIL lu_stall_pc: got %b/%b expected 0/0", pc_write, if_id_write); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_BUBBLE || ex_rs !== 5'd0 || ex_rt !== 5'd0 || stall_cnt !== 16'd1)
      $display("FAIL lu_bubble: got valid=%b ctrl=%h rs=%0d rt=%0d stall=%0d expected 0/0/0/0/1",
               ex_valid, ex_ctrl, ex_rs, ex_rt, stall_cnt); else n_pass++;
    n_checks++; if (pc_write !== 1'b1)
      $display("FAIL lu_after_pc: got %b expected 1", pc_write); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd5 || ex_rd !== 5'd6 || ex_rdata1 !== 32'hAAAA_0005 || ex_rdata2 !== 32'hBBBB_0007)
      $display("FAIL lu_dep_enter: got valid=%b rs=%0d rd=%0d d1=%h d2=%h expected 1/5/6/aaaa0005/bbbb0007",
               ex_valid, ex_rs, ex_rd, ex_rdata1, ex_rdata2); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd1)
      $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_flush_hazard;
    set_id(1'b1, 5'd2, 5'd5, 5'd0, 32'h100, 32'h0, 32'h8, C_LW);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 32'h1, 32'h2, 32'h0, C_ADD);
    flush = 1'b1;
    #1;
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1)
      $display("FAIL fh_pc_write: got %b/%b expected 1/1", pc_write, if_id_write); else n_pass++;
    tick();
    flush = 1'b0;
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_BUBBLE || flush_cnt !== 16'd1 || stall_cnt !== 16'd1)
      $display("FAIL fh_bubble: got valid=%b ctrl=%h flush=%0d stall=%0d expected 0/0/1/1",
               ex_valid, ex_ctrl, flush_cnt, stall_cnt); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_mem_busy;
    set_id(1'b1, 5'd3, 5'd5, 5'd0, 32'h200, 32'h0, 32'hC, C_LW);
    tick();
    set_id(1'b1, 5'd7, 5'd5, 5'd9, 32'h3, 32'h4, 32'h0, C_ADD);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pc_write !== 1'b0)
        $display("FAIL mb_pc_write[%0d]: got %b expected 0", i, pc_write); else n_pass++;
      tick();
      n_checks++; if (ex_valid !== 1'b1 || ex_rt !== 5'd5 || ex_ctrl !== C_LW || ex_rdata1 !== 32'h200 || stall_cnt !== 16'd1)
        $display("FAIL mb_hold[%0d]: got valid=%b rt=%0d ctrl=%h d1=%h stall=%0d expected 1/5/%h/200/1",
                 i, ex_valid, ex_rt, ex_ctrl, ex_rdata1, stall_cnt, C_LW); else n_pass++;
    end
    mem_busy = 1'b0;
    #1;
    n_checks++; if (pc_write !== 1'b0)
      $display("FAIL mb_release_pc: got %b expected 0", pc_write); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd2)
      $display("FAIL mb_bubble: got valid=%b stall=%0d expected 0/2", ex_valid, stall_cnt); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd7 || ex_rd !== 5'd9 || stall_cnt !== 16'd2)
      $display("FAIL mb_dep_enter: got valid=%b rs=%0d rd=%0d stall=%0d expected 1/7/9/2",
               ex_valid, ex_rs, ex_rd, stall_cnt); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0, C_ADD);
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_rd !== 5'd3 || ex_imm !== 32'hFFFF_FFF0)
      $display("FAIL b2b_a: got valid=%b rs=%0d rt=%0d rd=%0d imm=%h expected 1/1/2/3/fffffff0",
               ex_valid, ex_rs, ex_rt, ex_rd, ex_imm); else n_pass++;
    set_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h4444_4444, 32'h5555_5555, 32'h0000_0010, C_LW);
    tick();
    n_checks++; if (ex_rs !== 5'd4 || ex_rdata2 !== 32'h5555_5555 || ex_ctrl !== C_LW)
      $display("FAIL b2b_b: got rs=%0d d2=%h ctrl=%h expected 4/55555555/%h", ex_rs, ex_rdata2, ex_ctrl, C_LW); else n_pass++;
    // invalid slot: control forced to zero, no hazard even though rt matches
    set_id(1'b0, 5'd5, 5'd5, 5'd1, 32'h9, 32'h9, 32'h9, C_ADD);
    #1;
    n_checks++; if (pc_write !== 1'b1)
      $display("FAIL b2b_invalid_pc: got %b expected 1", pc_write); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_BUBBLE || stall_cnt !== 16'd2)
      $display("FAIL b2b_invalid: got valid=%b ctrl=%h stall=%0d expected 0/0/2", ex_valid, ex_ctrl, stall_cnt); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_saturate;
    // lw $5,0($5) repeated: each pair of edges yields one load-use stall
    set_id(1'b1, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
    for (int i = 0; i < 2 * ((1 << SMALL_W) + 5); i++) tick();
    n_checks++; if (s_stall_cnt !== 4'hF)
      $display("FAIL sat_small: got %h expected f", s_stall_cnt); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd23)
      $display("FAIL sat_wide: got %0d expected 23", stall_cnt); else n_pass++;
    n_checks++; if (s_flush_cnt !== 4'd1)
      $display("FAIL sat_small_flush: got %0d expected 1", s_flush_cnt); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid_stall;
    set_id(1'b1, 5'd2, 5'd5, 5'd0, 32'h100, 32'h0, 32'h8, C_LW);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 32'h1, 32'h2, 32'h0, C_ADD);
    mem_busy = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_rt !== 5'd0 || ex_ctrl !== CTRL_BUBBLE || stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
      $display("FAIL rst_mid: got valid=%b rt=%0d ctrl=%h stall=%0d flush=%0d expected all 0",
               ex_valid, ex_rt, ex_ctrl, stall_cnt, flush_cnt); else n_pass++;
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1)
      $display("FAIL rst_mid_pc: got %b/%b expected 1/1", pc_write, if_id_write); else n_pass++;
    @(negedge clk);
    mem_busy = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd5 || stall_cnt !== 16'd0)
      $display("FAIL rst_mid_resume: got valid=%b rs=%0d stall=%0d expected 1/5/0", ex_valid, ex_rs, stall_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw_zero();
    test_load_use();
    test_flush_hazard();
    test_mem_busy();
    test_back_to_back();
    test_saturate();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the 5-stage MIPS core, with built-in load-use hazard detection. It registers decoded operands and control from ID, inserts bubbles for load-use hazards and taken-branch flushes, and freezes on memory back-pressure. It drives the `Rs`/`Rt`/control inputs that the EX-stage forwarding unit and ALU consume. It also keeps saturating stall/flush statistics counters.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  rising-edge clock; one clock, reset is asynchronous and active-low
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register specifiers from ID
- `id_rdata1`, `id_rdata2`, `id_imm`  in  DATA_W each  register-file reads, sign-extended immediate
- `id_ctrl`  in  `ctrl_t`  `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `alu_src`, `reg_dst`, `alu_op[2:0]`
- `flush`  in  1  taken branch/jump resolved in EX; squash ID
- `mem_busy`  in  1  memory stage not ready; freeze whole front end
- `ex_valid`  out  1  EX holds a real instruction
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  to forwarding unit / dest mux
- `ex_rdata1`, `ex_rdata2`, `ex_imm`  out  DATA_W each  registered operands
- `ex_ctrl`  out  `ctrl_t`  registered control
- `pc_write`  out  1  PC may advance
- `if_id_write`  out  1  IF/ID may load
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counts

## Operation
- Hazard, combinational: `hazard = ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- Per-cycle priority, highest first:
  1. `mem_busy`: hold all `ex_*` registers. `pc_write = if_id_write = 0`. Counters unchanged.
  2. `flush`: load a bubble. `pc_write = if_id_write = 1`. `flush_cnt` +1.
  3. `hazard`: load a bubble. `pc_write = if_id_write = 0`. `stall_cnt` +1.
  4. Otherwise: load the ID fields. `ex_valid <= id_valid`. `pc_write = if_id_write = 1`.
- A bubble means `ex_valid = 0` and every `ex_ctrl` bit 0. Operand/specifier fields are also zeroed, so a bubble never matches in forwarding.
- When `id_valid = 0`, normal load also forces `ex_ctrl` to 0. No hazard is possible.
- Counters saturate at all-ones. They never wrap.
- Hazard needs at most one bubble: after it, the load has moved to MEM and the forwarding unit covers it.

## Timing
- Reset (async assert, sync-free release): all `ex_*` = 0, `ex_valid = 0`, both counters = 0.
- `pc_write` and `if_id_write` are combinational. They read 1 during reset because `ex_valid = 0` and `mem_busy` is ignored while `rst_n = 0`.
- Latency: ID fields appear on `ex_*` one cycle after the edge at which they are presented.
- Load-use: exactly one bubble cycle. The dependent instruction enters EX two edges after the load did.
- Flush and hazard asserted together: flush wins, the hazard stall is not taken, and `stall_cnt` does not increment.
- `mem_busy` held for N cycles freezes state for N edges. Pending hazard/flush are re-evaluated on release.
- Reset mid-stall: the registers clear immediately, with no residual stall.

## Structure
- Shared package `pipe_pkg` holds:
  - `ctrl_t` (packed struct above) and `CTRL_BUBBLE = '0`
  - `REG_ZERO = 5'd0`
  - forwarding select constants `FWD_REG = 3'b001`, `FWD_EXMEM = 3'b010`, `FWD_MEMWB = 3'b100`
- One sub-module, `load_use_detect`: pure combinational hazard compare, reusable by the ID-stage branch comparator.

## Test plan
- Reset release → all `ex_*` = 0, `pc_write = if_id_write = 1`, counters = 0.
- `lw $5` then `add $6,$5,$7` → one bubble cycle, `pc_write = 0` for exactly one cycle, `ex_rs = 5` on the cycle after the bubble, `stall_cnt = 1`.
- `lw $0` then a dependent `add` reading `$0` → no stall, `stall_cnt = 0`.
- `flush` and `hazard` asserted in the same cycle → bubble, `pc_write = 1`, `flush_cnt = 1`, `stall_cnt = 0`.
- `mem_busy` for 3 cycles while a hazard is pending → `ex_*` held for 3 edges. After release, one bubble follows and `stall_cnt` increments once.
- Force 2^CNT_W + 5 hazards → `stall_cnt` stays at 16'hFFFF.
